// File: rtl/mandel_iter_engine.sv
// Per-pixel Mandelbrot iteration core: iterates z <= z^2 + c from z = 0 and
// reports the iteration count at escape (|z|^2 > 4) or MAX_ITER if it never escapes.
module mandel_iter_engine #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC     = 12,
    parameter int unsigned MAX_ITER = 15,
    parameter int unsigned ITER_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic signed [WIDTH-1:0]  cr_i,
    input  logic signed [WIDTH-1:0]  ci_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ITER_W-1:0]        iter_o,
    output logic                     escaped_o
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned MAG_W  = PROD_W + 1;
    localparam logic signed [MAG_W-1:0] ESC_LIM = MAG_W'(64'd4 << FRAC);
    localparam logic [ITER_W-1:0]       N_MAX   = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q,   state_d;
    logic signed [WIDTH-1:0]   cr_q,      cr_d;
    logic signed [WIDTH-1:0]   ci_q,      ci_d;
    logic signed [WIDTH-1:0]   zr_q,      zr_d;
    logic signed [WIDTH-1:0]   zi_q,      zi_d;
    logic [ITER_W-1:0]         n_q,       n_d;
    logic                      busy_q,    busy_d;
    logic                      done_q,    done_d;
    logic [ITER_W-1:0]         iter_q,    iter_d;
    logic                      escaped_q, escaped_d;

    // Full-precision squares/cross term; mag is wide enough that it can never wrap.
    logic signed [PROD_W-1:0]  zr_x_c, zi_x_c;
    logic signed [PROD_W-1:0]  zr2_c, zi2_c, zri_c;
    logic signed [MAG_W-1:0]   mag_c;
    logic signed [WIDTH-1:0]   zr_nxt_c, zi_nxt_c;

    always_comb begin
        zr_x_c   = PROD_W'(zr_q);
        zi_x_c   = PROD_W'(zi_q);
        zr2_c    = (zr_x_c * zr_x_c) >>> FRAC;
        zi2_c    = (zi_x_c * zi_x_c) >>> FRAC;
        zri_c    = (zr_x_c * zi_x_c) >>> FRAC;
        mag_c    = MAG_W'(zr2_c) + MAG_W'(zi2_c);
        zr_nxt_c = WIDTH'(zr2_c - zi2_c + PROD_W'(cr_q));
        zi_nxt_c = WIDTH'((zri_c <<< 1) + PROD_W'(ci_q));
    end

    always_comb begin
        state_d   = state_q;
        cr_d      = cr_q;
        ci_d      = ci_q;
        zr_d      = zr_q;
        zi_d      = zi_q;
        n_d       = n_q;
        iter_d    = iter_q;
        escaped_d = escaped_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cr_d    = cr_i;
                    ci_d    = ci_i;
                    zr_d    = '0;
                    zi_d    = '0;
                    n_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (mag_c > ESC_LIM) begin
                    iter_d    = n_q;
                    escaped_d = 1'b1;
                    state_d   = S_DONE;
                end else if (n_q == N_MAX) begin
                    iter_d    = N_MAX;
                    escaped_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    zr_d = zr_nxt_c;
                    zi_d = zi_nxt_c;
                    n_d  = n_q + ITER_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered status follows the state being entered.
        busy_d = (state_d == S_CALC) || (state_d == S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cr_q      <= '0;
            ci_q      <= '0;
            zr_q      <= '0;
            zi_q      <= '0;
            n_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            iter_q    <= '0;
            escaped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cr_q      <= cr_d;
            ci_q      <= ci_d;
            zr_q      <= zr_d;
            zi_q      <= zi_d;
            n_q       <= n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            iter_q    <= iter_d;
            escaped_q <= escaped_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign iter_o    = iter_q;
    assign escaped_o = escaped_q;

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Self-checking bench for mandel_iter_engine: directed table, randomized points
// against an integer Mandelbrot model, start-ignore and mid-run reset sequences.
module tb_mandel_iter_engine;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned FRAC     = 12;
    localparam int unsigned MAX_ITER = 15;
    localparam int unsigned ITER_W   = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    start_i;
    logic signed [WIDTH-1:0] cr_i;
    logic signed [WIDTH-1:0] ci_i;
    logic                    busy_o;
    logic                    done_o;
    logic [ITER_W-1:0]       iter_o;
    logic                    escaped_o;

    int n_tests = 0;
    int n_fail  = 0;

    mandel_iter_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .cr_i(cr_i), .ci_i(ci_i),
        .busy_o(busy_o), .done_o(done_o), .iter_o(iter_o), .escaped_o(escaped_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] cr;
        logic [15:0] ci;
        int          exp_iter;
        bit          exp_esc;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap_w(input longint x);
        longint m;
        m = ((x % 65536) + 65536) % 65536;
        return (m >= 32768) ? m - 65536 : m;
    endfunction

    function automatic longint fdiv(input longint p);
        return (p >= 0) ? p / 4096 : -((-p + 4095) / 4096);
    endfunction

    // Plain fixed-point escape-time loop on integers scaled by 4096.
    function automatic void model(input longint cr, input longint ci,
                                  output int it, output bit esc);
        longint zr, zi, zr2, zi2, zri;
        zr = 0; zi = 0; it = int'(MAX_ITER); esc = 1'b0;
        for (int n = 0; n <= int'(MAX_ITER); n++) begin
            zr2 = fdiv(zr * zr);
            zi2 = fdiv(zi * zi);
            zri = fdiv(zr * zi);
            if (zr2 + zi2 > 4 * 4096) begin
                it = n; esc = 1'b1;
                return;
            end
            zr = wrap_w(zr2 - zi2 + cr);
            zi = wrap_w(2 * zri + ci);
        end
    endfunction

    // Start one pixel, optionally re-pulse start mid-run, then check result,
    // CALC-cycle count, busy and the single-cycle done pulse.
    task automatic run_pixel(input string name, input logic [15:0] cr, input logic [15:0] ci,
                             input int exp_iter, input bit exp_esc, input bit pulse_mid);
        int cnt;
        int extra;
        @(negedge clk_i);
        cr_i = cr; ci_i = ci; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cr_i = 16'h7abc; ci_i = 16'h8123;
        check({name, " busy_after_start"}, busy_o, 1);
        cnt = 0;
        while (!done_o && cnt < 60) begin
            @(negedge clk_i);
            cnt++;
            start_i = (pulse_mid && cnt == 1);
            if (start_i) begin cr_i = 16'h0; ci_i = 16'h0; end
        end
        start_i = 1'b0;
        check({name, " calc_cycles"}, cnt, exp_iter + 1);
        check({name, " iter"}, iter_o, exp_iter);
        check({name, " escaped"}, escaped_o, exp_esc);
        check({name, " busy_in_done"}, busy_o, 1);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (done_o) extra++;
        end
        check({name, " single_done"}, extra, 0);
        check({name, " idle_busy"}, busy_o, 0);
        check({name, " iter_hold"}, iter_o, exp_iter);
    endtask

    vec_t tbl[4];

    initial begin
        int it;
        bit esc;
        logic [15:0] rcr, rci;

        tbl[0] = '{16'h0000, 16'h0000, 15, 1'b0};
        tbl[1] = '{16'h1000, 16'h1000,  2, 1'b1};
        tbl[2] = '{16'hE000, 16'h0000, 15, 1'b0};
        tbl[3] = '{16'h0800, 16'h0000,  5, 1'b1};

        rst_i = 1'b1; start_i = 1'b0; cr_i = '0; ci_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset iter", iter_o, 0);
        check("reset escaped", escaped_o, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("idle no_done", done_o, 0);

        for (int i = 0; i < 4; i++)
            run_pixel($sformatf("table%0d", i), tbl[i].cr, tbl[i].ci,
                      tbl[i].exp_iter, tbl[i].exp_esc, 1'b0);

        // Start re-pulsed during CALC must not restart or queue a second pixel.
        run_pixel("restart_ignored", 16'h1000, 16'h1000, 2, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rcr = 16'($urandom_range(0, 16384) - 8192);
            rci = 16'($urandom_range(0, 16384) - 8192);
            model(longint'($signed(rcr)), longint'($signed(rci)), it, esc);
            run_pixel($sformatf("rand%0d", i), rcr, rci, it, esc, 1'b0);
        end

        // Leave a non-zero result behind, then reset in the middle of a long run.
        run_pixel("pre_reset", 16'h0800, 16'h0000, 5, 1'b1, 1'b0);
        @(negedge clk_i);
        cr_i = 16'h0; ci_i = 16'h0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("midreset busy", busy_o, 0);
        check("midreset done", done_o, 0);
        check("midreset iter", iter_o, 0);
        check("midreset escaped", escaped_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("post_reset no_done", done_o, 0);
        check("post_reset idle", busy_o, 0);
        run_pixel("after_reset", 16'h0000, 16'h0000, 15, 1'b0, 1'b0);
        run_pixel("after_reset2", 16'h1000, 16'h1000, 2, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
